rpsc_reset_ctrl: RTL and testbench



---
 rtl/rpsc_pkg.sv | 23 ++
 rtl/rpsc_reset_ctrl_if.sv | 22 ++
 rtl/rpsc_debounce.sv | 51 +++++
 rtl/rpsc_reset_ctrl.sv | 115 +++++++++++
 tb/tb_rpsc_reset_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/rpsc_pkg.sv
// Shared types and default timing for the RPSC reset/lamp-test controller.
package rpsc_pkg;

  typedef enum logic [1:0] {
    ST_POR    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_PULSE  = 2'd2,
    ST_SETTLE = 2'd3
  } rpsc_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_PULSE_CYCLES    = 8;
  localparam int unsigned DEF_SETTLE_CYCLES   = 32;
  localparam int unsigned DEF_LA_TIMEOUT      = 1024;

  function automatic int unsigned rpsc_max3(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rpsc_reset_ctrl_if.sv
// Panel-side inputs and card fan-out lines of the reset controller.
interface rpsc_reset_ctrl_if;
  logic btn_reset_raw;
  logic btn_la_raw;
  logic hold_key;
  logic fault_any;
  logic card_reset;
  logic card_reset_hold_error;
  logic card_LA_Test;
  logic busy;
  logic reset_failed;

  // master is the controller itself; slave is the panel/card side.
  modport master (
    input  btn_reset_raw, btn_la_raw, hold_key, fault_any,
    output card_reset, card_reset_hold_error, card_LA_Test, busy, reset_failed
  );
  modport slave (
    output btn_reset_raw, btn_la_raw, hold_key, fault_any,
    input  card_reset, card_reset_hold_error, card_LA_Test, busy, reset_failed
  );
endinterface

// File: rtl/rpsc_debounce.sv
// 2-FF synchronizer followed by a consecutive-sample debouncer with a rise pulse.
module rpsc_debounce
  import rpsc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count only while the synchronized level disagrees; any agreement restarts it.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/rpsc_reset_ctrl.sv
// Debounces RESET/LAMP TEST and sequences the card reset, hold-error and lamp-test lines.
module rpsc_reset_ctrl
  import rpsc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int unsigned LA_TIMEOUT      = DEF_LA_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  rpsc_reset_ctrl_if.master bus
);
  localparam int unsigned CW = $clog2(rpsc_max3(PULSE_CYCLES, SETTLE_CYCLES, LA_TIMEOUT) + 1);

  logic rst_lvl, rst_rise, la_lvl, la_rise;

  rpsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
    .clk(clk), .reset(reset), .raw(bus.btn_reset_raw), .level(rst_lvl), .rise(rst_rise)
  );
  rpsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_la (
    .clk(clk), .reset(reset), .raw(bus.btn_la_raw), .level(la_lvl), .rise(la_rise)
  );

  rpsc_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, la_cnt_q, la_cnt_d;
  logic          hold_sel_q, hold_sel_d, por_arm_q, por_arm_d;
  logic          la_on_q, la_on_d, rf_q, rf_d;
  logic          busy_q, busy_d, crst_q, crst_d, chre_q, chre_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_sel_d = hold_sel_q;
    por_arm_d  = 1'b1;
    rf_d       = rf_q;
    la_on_d    = 1'b0;
    la_cnt_d   = la_cnt_q;
    case (state_q)
      // POR is held for the first cycle after release, then always clears hold latches.
      ST_POR: if (por_arm_q) begin
        state_d    = ST_PULSE;
        hold_sel_d = 1'b1;
        cnt_d      = '0;
      end
      ST_IDLE: if (rst_rise && rst_lvl) begin
        state_d    = ST_PULSE;
        hold_sel_d = bus.hold_key;
        cnt_d      = '0;
      end
      ST_PULSE: if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_SETTLE: if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rf_d    = rf_q | bus.fault_any;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = ST_POR;
    endcase
    if (state_d == ST_PULSE && state_q != ST_PULSE) rf_d = 1'b0;

    // Lamp test only starts on a fresh edge seen while staying in IDLE.
    if (state_q == ST_IDLE && state_d == ST_IDLE) begin
      if (la_rise) begin
        la_on_d  = 1'b1;
        la_cnt_d = CW'(1);
      end else if (la_on_q && la_lvl && la_cnt_q < CW'(LA_TIMEOUT)) begin
        la_on_d  = 1'b1;
        la_cnt_d = la_cnt_q + 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
    crst_d = (state_d == ST_PULSE);
    chre_d = (state_d == ST_PULSE) && hold_sel_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_POR;
      cnt_q      <= '0;
      la_cnt_q   <= '0;
      hold_sel_q <= 1'b0;
      por_arm_q  <= 1'b0;
      la_on_q    <= 1'b0;
      rf_q       <= 1'b0;
      busy_q     <= 1'b0;
      crst_q     <= 1'b0;
      chre_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      la_cnt_q   <= la_cnt_d;
      hold_sel_q <= hold_sel_d;
      por_arm_q  <= por_arm_d;
      la_on_q    <= la_on_d;
      rf_q       <= rf_d;
      busy_q     <= busy_d;
      crst_q     <= crst_d;
      chre_q     <= chre_d;
    end
  end

  assign bus.card_reset            = crst_q;
  assign bus.card_reset_hold_error = chre_q;
  assign bus.card_LA_Test          = la_on_q;
  assign bus.busy                  = busy_q;
  assign bus.reset_failed          = rf_q;
endmodule

// File: tb/tb_rpsc_reset_ctrl.sv
// Directed test-plan scenarios plus a random phase, all checked against a timestamp model.
module tb_rpsc_reset_ctrl;
  localparam int D = 4, P = 8, S = 5, T = 20;
  localparam int BIG = 1 << 30;
  localparam int HN = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  rpsc_reset_ctrl_if bus ();

  rpsc_reset_ctrl #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .LA_TIMEOUT(T))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, fails = 0, cyc = 0;
  bit hist_r [0:HN-1];
  bit hist_l [0:HN-1];
  bit lvl_r, lvl_l, rise_r, rise_l, por_pend, hold_m, rf_m, la_on_m, cr_seen;
  int valid, busy_end = BIG, ps = BIG, la_start;
  logic e_cr, e_hre, e_la, e_busy, e_rf;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0b exp=%0b", tag, cyc, obs, exp);
    end
  endtask

  // A debounced level flips once the last D synchronized samples all disagree with it.
  function automatic bit settled(input bit is_la, input bit lvl, input int e);
    for (int k = 0; k < D; k++) begin
      if ((is_la ? hist_l[e-2-k] : hist_r[e-2-k]) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit idle_q, idle_d;
    if (reset) begin
      hist_r[cyc] = 1'b0; hist_l[cyc] = 1'b0;
      lvl_r = 0; lvl_l = 0; rise_r = 0; rise_l = 0; valid = 0;
      por_pend = 1; busy_end = BIG; ps = BIG; rf_m = 0; la_on_m = 0;
    end else begin
      hist_r[cyc] = bus.btn_reset_raw; hist_l[cyc] = bus.btn_la_raw;
      valid++;
      idle_q = !por_pend && (cyc - 1 >= busy_end);
      if (por_pend) begin
        por_pend = 0; ps = cyc + 1; hold_m = 1; busy_end = ps + P + S;
      end else if (idle_q && rise_r) begin
        ps = cyc; hold_m = bus.hold_key; busy_end = cyc + P + S;
      end
      idle_d = (cyc >= busy_end);
      if (idle_q && idle_d) begin
        if (rise_l) begin
          la_on_m = 1; la_start = cyc;
        end else if (!(la_on_m && lvl_l && (cyc - la_start) < T)) begin
          la_on_m = 0;
        end
      end else la_on_m = 0;
      if (cyc == ps) rf_m = 0;
      if (cyc == busy_end && bus.fault_any) rf_m = 1;
      rise_r = 0; rise_l = 0;
      if (valid >= D && settled(1'b0, lvl_r, cyc)) begin lvl_r = !lvl_r; rise_r = lvl_r; end
      if (valid >= D && settled(1'b1, lvl_l, cyc)) begin lvl_l = !lvl_l; rise_l = lvl_l; end
    end
    e_busy = !reset && (cyc < busy_end);
    e_cr   = !reset && (cyc >= ps) && (cyc < ps + P);
    e_hre  = e_cr && hold_m;
    e_la   = !reset && la_on_m;
    e_rf   = !reset && rf_m;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc >= HN - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HN - 1);
      $fatal(1, "cycle budget exhausted");
    end
    model_edge();
    @(negedge clk);
    chk("card_reset", bus.card_reset, e_cr);
    chk("card_reset_hold_error", bus.card_reset_hold_error, e_hre);
    chk("card_LA_Test", bus.card_LA_Test, e_la);
    chk("busy", bus.busy, e_busy);
    chk("reset_failed", bus.reset_failed, e_rf);
    if (bus.card_reset) cr_seen = 1;
  endtask

  initial begin
    int t, len;
    bit prev_la;
    bus.btn_reset_raw = 0; bus.btn_la_raw = 0; bus.hold_key = 0; bus.fault_any = 0;
    repeat (5) tick();
    chk("reset_busy_zero", bus.busy, 1'b0);

    // Power-on sequence
    reset = 0;
    tick(); chk("s1_por_busy", bus.busy, 1'b1); chk("s1_por_nopulse", bus.card_reset, 1'b0);
    tick(); chk("s1_pulse_start", bus.card_reset, 1'b1); chk("s1_hre", bus.card_reset_hold_error, 1'b1);
    repeat (7) tick(); chk("s1_pulse_last", bus.card_reset, 1'b1);
    tick(); chk("s1_pulse_end", bus.card_reset, 1'b0); chk("s1_settle_busy", bus.busy, 1'b1);
    repeat (4) tick(); chk("s1_busy_last", bus.busy, 1'b1);
    tick(); chk("s1_idle", bus.busy, 1'b0); chk("s1_rf", bus.reset_failed, 1'b0);
    repeat (10) tick();

    // Held RESET, hold_key=0
    bus.btn_reset_raw = 1; t = cyc;
    repeat (6) tick(); chk("s2_before", bus.card_reset, 1'b0);
    tick(); chk("s2_start", bus.card_reset, 1'b1); chk("s2_no_hre", bus.card_reset_hold_error, 1'b0);
    repeat (7) tick(); chk("s2_last", bus.card_reset, 1'b1);
    tick(); chk("s2_end", bus.card_reset, 1'b0);
    cr_seen = 0; repeat (40) tick(); chk("s2_single", cr_seen, 1'b0);
    bus.btn_reset_raw = 0; repeat (10) tick();

    // hold_key=1 with a fault that never clears
    bus.hold_key = 1; bus.fault_any = 1; bus.btn_reset_raw = 1;
    repeat (7) tick(); chk("s3_start", bus.card_reset, 1'b1); chk("s3_hre", bus.card_reset_hold_error, 1'b1);
    repeat (12) tick(); chk("s3_rf_pre", bus.reset_failed, 1'b0);
    tick(); chk("s3_rf_set", bus.reset_failed, 1'b1);
    bus.btn_reset_raw = 0; repeat (15) tick(); chk("s3_rf_sticky", bus.reset_failed, 1'b1);
    bus.fault_any = 0; bus.btn_reset_raw = 1;
    repeat (6) tick(); chk("s3_rf_hold", bus.reset_failed, 1'b1);
    tick(); chk("s3_rf_clear", bus.reset_failed, 1'b0);
    bus.btn_reset_raw = 0; bus.hold_key = 0; repeat (25) tick();

    // Short glitches never get through
    cr_seen = 0;
    repeat (10) begin
      bus.btn_reset_raw = 1; repeat (3) tick();
      bus.btn_reset_raw = 0; repeat (3) tick();
    end
    repeat (10) tick(); chk("s4_no_reset", cr_seen, 1'b0);

    // Lamp test with timeout, then re-press
    bus.btn_la_raw = 1; t = cyc;
    repeat (6) tick(); chk("s5_before", bus.card_LA_Test, 1'b0);
    tick(); chk("s5_start", bus.card_LA_Test, 1'b1);
    repeat (19) tick(); chk("s5_last", bus.card_LA_Test, 1'b1);
    tick(); chk("s5_timeout", bus.card_LA_Test, 1'b0);
    repeat (10) tick(); chk("s5_stays_off", bus.card_LA_Test, 1'b0);
    bus.btn_la_raw = 0; repeat (8) tick();
    bus.btn_la_raw = 1; repeat (7) tick(); chk("s5_repress", bus.card_LA_Test, 1'b1);

    // RESET during lamp test, then a system reset mid-PULSE
    bus.btn_reset_raw = 1; prev_la = 0;
    for (int i = 0; i < 20 && !bus.busy; i++) begin
      prev_la = bus.card_LA_Test; tick();
    end
    chk("s6_busy_rose", bus.busy, 1'b1);
    chk("s6_la_drop", bus.card_LA_Test, 1'b0);
    chk("s6_la_was_on", prev_la, 1'b1);
    repeat (2) tick();
    reset = 1; tick();
    chk("s6_rst_cr", bus.card_reset, 1'b0); chk("s6_rst_busy", bus.busy, 1'b0);
    chk("s6_rst_hre", bus.card_reset_hold_error, 1'b0);
    tick(); reset = 0;
    tick(); chk("s6_por_busy", bus.busy, 1'b1);
    tick(); chk("s6_por_pulse", bus.card_reset, 1'b1); chk("s6_por_hre", bus.card_reset_hold_error, 1'b1);
    repeat (20) tick(); chk("s6_la_consumed", bus.card_LA_Test, 1'b0);
    bus.btn_reset_raw = 0; bus.btn_la_raw = 0; repeat (10) tick();

    // Random phase
    for (int n = 0; n < 300; n++) begin
      bus.btn_reset_raw = ($urandom_range(0, 3) == 0);
      bus.btn_la_raw    = ($urandom_range(0, 1) == 1);
      bus.hold_key      = ($urandom_range(0, 1) == 1);
      bus.fault_any     = ($urandom_range(0, 2) == 0);
      len = int'($urandom_range(1, 10));
      if ($urandom_range(0, 29) == 0) begin reset = 1; len = 2; end
      else reset = 0;
      repeat (len) tick();
    end
    reset = 0; repeat (30) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
